// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// fifo_rd_pkg : shared types and constants for the FIFO read controller
// Revision    : 1.0
// ============================================================================
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
// rd_skid_buf : 2-entry first-word-fall-through skid buffer for FIFO read data
// Revision    : 1.0
// ============================================================================
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [SKID_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                             wr_ptr_q, wr_ptr_d;
  logic                             rd_ptr_q, rd_ptr_d;
  logic [1:0]                       count_q, count_d;
  logic                             store;
  logic                             drain;

  always_comb begin
    // An empty buffer passes the arriving word straight through to the output.
    out_valid = (count_q != 2'd0) || push;
    out_data  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : push_data;
    occupancy = count_q;

    store = push && !(pop && (count_q == 2'd0));
    drain = pop && (count_q != 2'd0);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (drain) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(store) - 2'(drain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl : burst reader pulling words from a FIFO onto a valid/ready stream
// Revision     : 1.0
// ============================================================================
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_rq,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      rd_count
);

  rd_state_e        state_q, state_d;
  logic [LEN_W-1:0] req_left_q, req_left_d;
  logic [LEN_W-1:0] out_left_q, out_left_d;
  logic             in_flight_q, in_flight_d;
  logic [15:0]      rd_count_q, rd_count_d;

  logic             skid_valid;
  logic [1:0]       skid_occ;
  logic [1:0]       pending;
  logic             xfer;

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (r_clk),
    .rst_n     (rst_n),
    .push      (in_flight_q),
    .push_data (rdata),
    .pop       (xfer),
    .out_valid (skid_valid),
    .out_data  (m_data),
    .occupancy (skid_occ)
  );

  always_comb begin
    // Words already owed to the skid buffer; never request beyond its depth.
    pending = skid_occ + {1'b0, in_flight_q};
    rd_rq   = rst_n && (state_q == READ) && !empty && (req_left_q != '0)
              && (pending < 2'(SKID_DEPTH));
    m_valid = rst_n && skid_valid;
    xfer    = m_valid && m_ready;
    m_last  = m_valid && (out_left_q == LEN_W'(1));
    done    = xfer && m_last;
    busy    = rst_n && (state_q != IDLE);

    state_d     = state_q;
    req_left_d  = req_left_q;
    out_left_d  = out_left_q;
    in_flight_d = rd_rq;
    rd_count_d  = rd_count_q + 16'(in_flight_q);

    if (rd_rq) begin
      req_left_d = req_left_q - LEN_W'(1);
    end
    if (xfer) begin
      out_left_d = out_left_q - LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          state_d    = READ;
          req_left_d = burst_len;
          out_left_d = burst_len;
        end
      end
      READ: begin
        if (rd_rq && (req_left_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_left_q  <= '0;
      out_left_q  <= '0;
      in_flight_q <= 1'b0;
      rd_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      req_left_q  <= req_left_d;
      out_left_q  <= out_left_d;
      in_flight_q <= in_flight_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_ctrl : scoreboard bench with a FIFO model and random ready patterns
// Revision        : 1.0
// ============================================================================
module tb_fifo_rd_ctrl;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int MEM_N = 1024;

  logic             r_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             empty;
  logic [WIDTH-1:0] rdata = '0;
  logic             rd_rq;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             busy;
  logic             done;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [15:0]      rd_count;

  logic [WIDTH-1:0] mem [MEM_N];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic             fifo_flush = 1'b0;
  int               outstanding = 0;
  int               rdy_mode = 0;

  logic [WIDTH-1:0] exp_data_q [$];
  int               exp_len_q [$];
  logic [31:0]      model_words = '0;
  int               checks = 0;
  int               errors = 0;
  int               done_cnt = 0;
  int               idx = 0;
  logic             lastexp;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  fifo_rd_ctrl #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .r_clk     (r_clk),
    .rst_n     (rst_n),
    .empty     (empty),
    .rdata     (rdata),
    .rd_rq     (rd_rq),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .rd_count  (rd_count)
  );

  always #5 r_clk = ~r_clk;

  assign empty = (rd_ptr == wr_ptr);

  // FIFO model: registered read data, one word per accepted request.
  always @(posedge r_clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (rd_rq) begin
      rdata  <= mem[rd_ptr % MEM_N];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Words requested but not yet delivered downstream.
  always @(posedge r_clk) begin
    if (!rst_n) outstanding = 0;
    else outstanding = outstanding + int'(rd_rq) - int'(m_valid && m_ready);
  end

  initial begin
    forever begin
      @(posedge r_clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every downstream transfer.
  always @(negedge r_clk) begin
    if (!rst_n) begin
      idx        = 0;
      prev_stall = 1'b0;
    end else begin
      chk("no_underflow", 32'(rd_rq && empty), 32'(0));
      chk("skid_bound", 32'(rd_rq && (outstanding >= 2)), 32'(0));
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'(1));
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_data_q.size() == 0 || exp_len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=0x%0h required=none", m_data);
        end else begin
          lastexp = (idx == exp_len_q[0] - 1);
          chk("m_data", 32'(m_data), 32'(exp_data_q.pop_front()));
          chk("m_last", 32'(m_last), 32'(lastexp));
          chk("done_on_last", 32'(done), 32'(lastexp));
          if (lastexp) begin
            void'(exp_len_q.pop_front());
            idx = 0;
          end else begin
            idx++;
          end
        end
      end else begin
        chk("done_idle", 32'(done), 32'(0));
      end
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    mem[wr_ptr % MEM_N] = d;
    wr_ptr++;
    exp_data_q.push_back(d);
  endtask

  task automatic do_start(input int len, input bit accept);
    start     = 1'b1;
    burst_len = LEN_W'(len);
    if (accept) begin
      exp_len_q.push_back(len);
      model_words = model_words + 32'(len);
    end
    tick();
    start     = 1'b0;
    burst_len = '0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    @(negedge r_clk);
    while (busy && n < bound) begin
      @(negedge r_clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    tick();
    chk({name, "_rd_count"}, 32'(rd_count), 32'(model_words[15:0]));
    chk({name, "_drained"}, 32'(exp_data_q.size()), 32'(0));
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge r_clk);
      chk("rst_rd_rq", 32'(rd_rq), 32'(0));
      chk("rst_m_valid", 32'(m_valid), 32'(0));
      chk("rst_m_last", 32'(m_last), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      tick();
    end
    rst_n = 1'b1;
    @(negedge r_clk);
    chk("rst_rd_count", 32'(rd_count), 32'(0));
    chk("rst_idle", 32'(busy), 32'(0));
    chk("rst_no_valid", 32'(m_valid), 32'(0));
    tick();
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    exp_data_q.delete();
    exp_len_q.delete();
    model_words = '0;
  endtask

  initial begin
    #1_200_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int d0;
    int len;

    rdy_mode = 0;
    apply_reset(3);

    // Burst of 4 with known data, full throughput.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    d0 = done_cnt;
    do_start(4, 1'b1);
    @(negedge r_clk);
    chk("lat_rd_rq", 32'(rd_rq), 32'(1));
    chk("lat_no_valid", 32'(m_valid), 32'(0));
    tick();
    @(negedge r_clk);
    chk("lat_first_valid", 32'(m_valid), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge r_clk);
      chk("throughput_valid", 32'(m_valid), 32'(1));
    end
    wait_idle(50, "b4");
    chk("b4_done_count", 32'(done_cnt - d0), 32'(1));
    chk("b4_rd_count", 32'(rd_count), 32'(4));

    // Burst of 16 with ready toggling every cycle.
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) push_word(WIDTH'($urandom));
    do_start(16, 1'b1);
    wait_idle(200, "b16");

    // Burst of 8 where the FIFO runs dry after 3 words.
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) push_word(WIDTH'($urandom));
    do_start(8, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge r_clk);
      chk("starved_busy", 32'(busy), 32'(1));
      tick();
    end
    for (int i = 0; i < 5; i++) push_word(WIDTH'($urandom));
    wait_idle(100, "b8");

    // Zero-length start and start during an active burst are ignored.
    d0 = done_cnt;
    do_start(0, 1'b0);
    @(negedge r_clk);
    chk("len0_ignored", 32'(busy), 32'(0));
    tick();
    for (int i = 0; i < 4; i++) push_word(WIDTH'($urandom));
    do_start(4, 1'b1);
    do_start(5, 1'b0);
    wait_idle(100, "ign");
    chk("ign_done_count", 32'(done_cnt - d0), 32'(1));

    // Reset in the middle of a burst.
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom));
    do_start(8, 1'b1);
    tick();
    tick();
    tick();
    d0 = done_cnt;
    apply_reset(2);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'(0));

    // Random bursts under random ready patterns.
    for (int b = 0; b < 8; b++) begin
      rdy_mode = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++) push_word(WIDTH'($urandom));
      do_start(len, 1'b1);
      wait_idle(400, "rnd");
    end

    // 65537 words after reset: rd_count wraps to 1.
    rdy_mode = 0;
    apply_reset(1);
    for (int b = 0; b < 258; b++) begin
      len = (b < 257) ? 255 : 2;
      for (int i = 0; i < len; i++) push_word(WIDTH'(b + i));
      do_start(len, 1'b1);
      wait_idle(600, "wrap");
    end
    chk("rd_count_wrap", 32'(rd_count), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width, matching the FIFO rdata width.
REQ-002 Parameter LEN_W, default 8, SHALL set the burst_len width.
REQ-003 r_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the synchronous, active-low reset, sampled on r_clk.
REQ-005 empty  in  1  SHALL be the FIFO empty flag (r_clk domain).
REQ-006 rdata  in  WIDTH  SHALL be FIFO read data, valid on the first r_clk edge after a cycle with rd_rq=1 and empty=0.
REQ-007 rd_rq  out  1  SHALL be the FIFO read request.
REQ-008 start  in  1  SHALL request one burst; sampled only in IDLE.
REQ-009 burst_len  in  LEN_W  SHALL give the words per burst; sampled with start.
REQ-010 busy  out  1  SHALL be high while not in IDLE.
REQ-011 done  out  1  SHALL pulse for one cycle at burst completion.
REQ-012 m_valid  out  1, m_ready  in  1, m_data  out  WIDTH, m_last  out  1  SHALL form the downstream valid/ready stream.
REQ-013 rd_count  out  16  SHALL count words accepted from the FIFO since reset, wrapping at 2^16.

Function
REQ-014 FSM states SHALL be IDLE, READ, DRAIN.
REQ-015 IDLE -> READ when start=1 and burst_len!=0; burst_len latched into req_left and out_left.
REQ-016 start with burst_len=0 SHALL be ignored: no state change, no done pulse.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 rd_rq SHALL be driven combinationally: state==READ, empty=0, req_left!=0, and (skid occupancy + in-flight) < 2.
REQ-019 rd_rq SHALL never assert while empty=1; no underflow reads.
REQ-020 Each cycle with rd_rq=1 SHALL decrement req_left by 1 and set in_flight for the next cycle.
REQ-021 READ -> DRAIN on the cycle req_left reaches 0.
REQ-022 Returned rdata SHALL enter a 2-entry skid buffer the cycle after the request; no word is dropped or duplicated under any m_ready pattern.
REQ-023 m_data SHALL present words in FIFO order; m_valid/m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024 A transfer occurs when m_valid=1 and m_ready=1; each transfer decrements out_left.
REQ-025 m_last SHALL be 1 exactly on the word transferred when out_left==1.
REQ-026 DRAIN -> IDLE on the cycle the last word transfers; done=1 on that cycle.
REQ-027 Simultaneous skid push and pop SHALL leave occupancy unchanged.
REQ-028 Sustained throughput SHALL be 1 word/cycle when empty=0 and m_ready=1; first-word latency from start is 2 cycles (start edge -> rd_rq, next edge -> m_valid).
REQ-029 rd_count SHALL increment on each accepted rdata word; 0xFFFF+1 wraps to 0x0000.

Reset
REQ-030 On rst_n=0 at an r_clk edge: state=IDLE, req_left=0, out_left=0, skid empty, in_flight=0, rd_count=0.
REQ-031 During reset, rd_rq, m_valid, m_last, busy, done SHALL be 0.
REQ-032 Reset mid-burst SHALL abort the burst without a done pulse; rdata returning after reset SHALL be discarded.

Structure
REQ-033 Package fifo_rd_pkg SHALL hold the state enum typedef and constant SKID_DEPTH=2.
REQ-034 The skid buffer SHALL be the single sub-module rd_skid_buf (WIDTH-parameterized, push/pop/occupancy).
REQ-035 Implementation SHALL be synthesizable, free of latches, 120-400 RTL lines.

Verification
REQ-036 Reset: rst_n=0 for 2 cycles mid-burst -> all outputs 0, state IDLE, rd_count=0, no done.
REQ-037 Burst 4, FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1 -> m_data 0x11..0x44 on consecutive cycles, m_last on 0x44, one done pulse, rd_count=4.
REQ-038 Burst 16, m_ready toggling 1/0 each cycle -> 16 words in order, none lost, rd_rq never asserted with occupancy+in_flight=2.
REQ-039 Burst 8 with FIFO empty after 3 words, refilled 20 cycles later -> rd_rq low while empty=1, all 8 words delivered, busy held throughout.
REQ-040 start with burst_len=0, and start during an active burst -> both ignored, no extra words, single done.
REQ-041 Sequential bursts totalling 65537 words -> rd_count wraps to 0x0001.
